// File: rtl/img_window_scanner_if.sv
// img_window_scanner_if: load, window and write-back channels of the window scanner.
interface img_window_scanner_if #(
  parameter int BIT_LENGTH = 5,
  parameter int PIX_PER_CYCLE = 3,
  parameter int CW = 5
);
  logic load_valid;
  logic load_ready;
  logic [PIX_PER_CYCLE*BIT_LENGTH-1:0] pixel_in;
  logic start;
  logic border_mode;
  logic win_valid;
  logic win_ready;
  logic [9*BIT_LENGTH-1:0] win_data;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic win_last;
  logic wb_valid;
  logic [BIT_LENGTH-1:0] wb_data;
  logic busy;
  logic pass_done;
  modport master (
    output load_valid, pixel_in, start, border_mode, win_ready, wb_valid, wb_data,
    input load_ready, win_valid, win_data, win_row, win_col, win_last, busy, pass_done
  );
  modport slave (
    input load_valid, pixel_in, start, border_mode, win_ready, wb_valid, wb_data,
    output load_ready, win_valid, win_data, win_row, win_col, win_last, busy, pass_done
  );
endinterface

// File: rtl/img_window_scanner.sv
// img_window_scanner: dual-bank frame buffer streaming 3x3 windows and collecting one result per window.
module img_window_scanner #(
  parameter int IMG_DIM = 20,
  parameter int BIT_LENGTH = 5,
  parameter int PIX_PER_CYCLE = 3
) (
  input logic clk,
  input logic reset,
  img_window_scanner_if.slave bus
);
  localparam int CW = $clog2(IMG_DIM);
  localparam int W = BIT_LENGTH;
  localparam int N = IMG_DIM * IMG_DIM;
  localparam int AW = $clog2(N);
  localparam int NW = $clog2(N + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SCAN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] mem_q [2][N];
  logic [W-1:0] mem_d [2][N];
  logic loaded_q, loaded_d, active_q, active_d, mode_q, mode_d, issued_q, issued_d;
  logic [NW-1:0] ld_cnt_q, ld_cnt_d, wb_cnt_q, wb_cnt_d;
  logic [CW-1:0] cur_r_q, cur_r_d, cur_c_q, cur_c_d, wb_r_q, wb_r_d, wb_c_q, wb_c_d;
  logic win_valid_q, win_valid_d, win_last_q, win_last_d;
  logic [9*W-1:0] win_data_q, win_data_d;
  logic [CW-1:0] win_row_q, win_row_d, win_col_q, win_col_d;
  logic [CW-1:0] lo, hi;
  logic [CW-1:0] rows [3];
  logic [CW-1:0] cols [3];
  logic [NW-1:0] total;
  logic [AW-1:0] wb_addr;
  logic [9*W-1:0] taps;
  logic ld_fire, ld_final, xfer, advance, wb_fire, cur_last;
  assign lo = mode_q ? '0 : CW'(1);
  assign hi = mode_q ? CW'(IMG_DIM - 1) : CW'(IMG_DIM - 2);
  assign total = mode_q ? NW'(N) : NW'((IMG_DIM - 2) * (IMG_DIM - 2));
  assign cur_last = cur_r_q == hi && cur_c_q == hi;
  assign xfer = win_valid_q && bus.win_ready;
  assign advance = state_q == SCAN && !issued_q && (!win_valid_q || bus.win_ready);
  assign ld_fire = bus.load_valid && bus.load_ready;
  assign ld_final = {1'b0, ld_cnt_q} + (NW + 1)'(PIX_PER_CYCLE) >= (NW + 1)'(N);
  assign wb_fire = !reset && bus.wb_valid && (state_q == SCAN || state_q == DRAIN) && wb_cnt_q < total;
  assign wb_addr = AW'(wb_r_q) * AW'(IMG_DIM) + AW'(wb_c_q);
  assign bus.load_ready = !reset && (state_q == IDLE || state_q == LOAD);
  assign bus.win_valid = win_valid_q;
  assign bus.win_data = win_data_q;
  assign bus.win_row = win_row_q;
  assign bus.win_col = win_col_q;
  assign bus.win_last = win_last_q;
  assign bus.busy = state_q != IDLE;
  assign bus.pass_done = state_q == DONE;
  // Edge clamping only ever triggers in replicate mode; interior centres never touch the border.
  always_comb begin
    rows[0] = cur_r_q == '0 ? cur_r_q : cur_r_q - CW'(1);
    rows[1] = cur_r_q;
    rows[2] = cur_r_q == CW'(IMG_DIM - 1) ? cur_r_q : cur_r_q + CW'(1);
    cols[0] = cur_c_q == '0 ? cur_c_q : cur_c_q - CW'(1);
    cols[1] = cur_c_q;
    cols[2] = cur_c_q == CW'(IMG_DIM - 1) ? cur_c_q : cur_c_q + CW'(1);
    taps = '0;
    for (int i = 0; i < 9; i++)
      taps[i*W +: W] = mem_q[active_q][AW'(rows[i/3]) * AW'(IMG_DIM) + AW'(cols[i%3])];
  end
  // Loads fill both banks so interior-mode results inherit the original border.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < PIX_PER_CYCLE; j++)
      if (ld_fire && {1'b0, ld_cnt_q} + (NW + 1)'(j) < (NW + 1)'(N)) begin
        mem_d[0][AW'(ld_cnt_q + NW'(j))] = bus.pixel_in[j*W +: W];
        mem_d[1][AW'(ld_cnt_q + NW'(j))] = bus.pixel_in[j*W +: W];
      end
    if (wb_fire) mem_d[!active_q][wb_addr] = bus.wb_data;
  end
  always_comb begin
    state_d = state_q;
    loaded_d = loaded_q;
    active_d = active_q;
    mode_d = mode_q;
    issued_d = issued_q || (advance && cur_last);
    ld_cnt_d = ld_fire ? (ld_final ? '0 : ld_cnt_q + NW'(PIX_PER_CYCLE)) : ld_cnt_q;
    wb_cnt_d = wb_fire ? wb_cnt_q + NW'(1) : wb_cnt_q;
    wb_c_d = wb_fire ? (wb_c_q == hi ? lo : wb_c_q + CW'(1)) : wb_c_q;
    wb_r_d = wb_fire && wb_c_q == hi ? wb_r_q + CW'(1) : wb_r_q;
    cur_c_d = advance ? (cur_c_q == hi ? lo : cur_c_q + CW'(1)) : cur_c_q;
    cur_r_d = advance && cur_c_q == hi ? cur_r_q + CW'(1) : cur_r_q;
    win_valid_d = advance || (win_valid_q && !xfer);
    win_last_d = advance ? cur_last : win_last_q && !xfer;
    win_data_d = advance ? taps : win_data_q;
    win_row_d = advance ? cur_r_q : win_row_q;
    win_col_d = advance ? cur_c_q : win_col_q;
    case (state_q)
      IDLE:
        if (ld_fire) begin
          state_d = ld_final ? IDLE : LOAD;
          loaded_d = ld_final;
          active_d = 1'b0;
        end else if (bus.start && loaded_q) begin
          state_d = SCAN;
          mode_d = bus.border_mode;
          issued_d = 1'b0;
          cur_r_d = bus.border_mode ? '0 : CW'(1);
          cur_c_d = cur_r_d;
          wb_r_d = cur_r_d;
          wb_c_d = cur_r_d;
          wb_cnt_d = '0;
        end
      LOAD:
        if (ld_fire && ld_final) begin
          state_d = IDLE;
          loaded_d = 1'b1;
          active_d = 1'b0;
        end
      SCAN: if (xfer && win_last_q) state_d = wb_cnt_d == total ? DONE : DRAIN;
      DRAIN: if (wb_cnt_d == total) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        active_d = !active_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      loaded_q <= 1'b0;
      active_q <= 1'b0;
      mode_q <= 1'b0;
      issued_q <= 1'b0;
      ld_cnt_q <= '0;
      wb_cnt_q <= '0;
      cur_r_q <= '0;
      cur_c_q <= '0;
      wb_r_q <= '0;
      wb_c_q <= '0;
      win_valid_q <= 1'b0;
      win_last_q <= 1'b0;
      win_data_q <= '0;
      win_row_q <= '0;
      win_col_q <= '0;
    end else begin
      state_q <= state_d;
      loaded_q <= loaded_d;
      active_q <= active_d;
      mode_q <= mode_d;
      issued_q <= issued_d;
      ld_cnt_q <= ld_cnt_d;
      wb_cnt_q <= wb_cnt_d;
      cur_r_q <= cur_r_d;
      cur_c_q <= cur_c_d;
      wb_r_q <= wb_r_d;
      wb_c_q <= wb_c_d;
      win_valid_q <= win_valid_d;
      win_last_q <= win_last_d;
      win_data_q <= win_data_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
    end
endmodule
